// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: decodes the opcode into
// mux/enable controls, stretches memory states on mem_ready, traps illegal ops.
module multicycle_ctrl_fsm #(
  parameter bit          EXT_EN = 1'b1,
  parameter bit          MEM_HS = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             branch,
  output logic             bne,
  output logic             zeroext,
  output logic [1:0]       memtoreg,
  output logic [1:0]       regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             instr_retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             trap,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPEEX  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCHEX = 4'd8,
    S_IMMEX    = 4'd9,
    S_IMMWB    = 4'd10,
    S_JEX      = 4'd11,
    S_JALEX    = 4'd12,
    S_TRAP     = 4'd13,
    S_RSV14    = 4'd14,
    S_RSV15    = 4'd15
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready;
  logic             ext_ok;
  logic             is_logic_imm;

  assign ready        = MEM_HS ? mem_ready : 1'b1;
  assign ext_ok       = EXT_EN;
  assign is_logic_imm = (op == OP_ANDI) || (op == OP_ORI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pcwrite       = 1'b0;
    memwrite      = 1'b0;
    irwrite       = 1'b0;
    regwrite      = 1'b0;
    alusrca       = 1'b0;
    iord          = 1'b0;
    branch        = 1'b0;
    bne           = 1'b0;
    zeroext       = 1'b0;
    memtoreg      = 2'b00;
    regdst        = 2'b00;
    alusrcb       = 2'b00;
    pcsrc         = 2'b00;
    aluop         = 2'b00;
    instr_retired = 1'b0;
    trap          = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:           state_d = S_MEMADR;
          OP_RTYPE:               state_d = S_RTYPEEX;
          OP_BEQ:                 state_d = S_BRANCHEX;
          OP_ADDI:                state_d = S_IMMEX;
          OP_J:                   state_d = S_JEX;
          OP_BNE:                 state_d = ext_ok ? S_BRANCHEX : S_TRAP;
          OP_ANDI, OP_ORI:        state_d = ext_ok ? S_IMMEX : S_TRAP;
          OP_JAL:                 state_d = ext_ok ? S_JALEX : S_TRAP;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite      = 1'b1;
        memtoreg      = 2'b01;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite      = 1'b1;
        regdst        = 2'b01;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCHEX: begin
        alusrca       = 1'b1;
        aluop         = 2'b01;
        pcsrc         = 2'b01;
        branch        = (op == OP_BEQ);
        bne           = (op == OP_BNE);
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (is_logic_imm) begin
          aluop   = 2'b11;
          zeroext = 1'b1;
        end
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JEX: begin
        pcsrc         = 2'b10;
        pcwrite       = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JALEX: begin
        pcsrc         = 2'b10;
        pcwrite       = 1'b1;
        regwrite      = 1'b1;
        regdst        = 2'b10;
        memtoreg      = 2'b10;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // FETCH drives write strobes while the async reset is still held, so mask them
    if (!reset_n) begin
      pcwrite       = 1'b0;
      memwrite      = 1'b0;
      irwrite       = 1'b0;
      regwrite      = 1'b0;
      instr_retired = 1'b0;
    end

    cnt_d = instr_retired ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: a default instance plus an EXT_EN=0/MEM_HS=0/CNT_W=2
// instance, checked against per-instruction expected state paths and control tables.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [5:0] op1, op2;
  logic       mr1, mr2;

  logic pw1, mw1, iw1, rw1, asa1, iord1, br1, bn1, ze1, ret1, trap1;
  logic [1:0] m2r1, rd1, asb1, ps1, ao1;
  logic [31:0] cnt1;
  logic [3:0]  st1;
  logic pw2, mw2, iw2, rw2, asa2, iord2, br2, bn2, ze2, ret2, trap2;
  logic [1:0] m2r2, rd2, asb2, ps2, ao2;
  logic [1:0] cnt2;
  logic [3:0] st2;

  multicycle_ctrl_fsm u_dut1 (
    .clk(clk), .reset_n(reset_n), .op(op1), .mem_ready(mr1),
    .pcwrite(pw1), .memwrite(mw1), .irwrite(iw1), .regwrite(rw1),
    .alusrca(asa1), .iord(iord1), .branch(br1), .bne(bn1), .zeroext(ze1),
    .memtoreg(m2r1), .regdst(rd1), .alusrcb(asb1), .pcsrc(ps1), .aluop(ao1),
    .instr_retired(ret1), .instr_count(cnt1), .trap(trap1), .state(st1)
  );

  multicycle_ctrl_fsm #(.EXT_EN(1'b0), .MEM_HS(1'b0), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .op(op2), .mem_ready(mr2),
    .pcwrite(pw2), .memwrite(mw2), .irwrite(iw2), .regwrite(rw2),
    .alusrca(asa2), .iord(iord2), .branch(br2), .bne(bn2), .zeroext(ze2),
    .memtoreg(m2r2), .regdst(rd2), .alusrcb(asb2), .pcsrc(ps2), .aluop(ao2),
    .instr_retired(ret2), .instr_count(cnt2), .trap(trap2), .state(st2)
  );

  logic [20:0] ctl1, ctl2;
  assign ctl1 = {pw1, mw1, iw1, rw1, asa1, iord1, br1, bn1, ze1, m2r1, rd1, asb1, ps1, ao1, ret1, trap1};
  assign ctl2 = {pw2, mw2, iw2, rw2, asa2, iord2, br2, bn2, ze2, m2r2, rd2, asb2, ps2, ao2, ret2, trap2};

  int unsigned passed = 0, total = 0;
  int unsigned m_cnt1 = 0, m_cnt2 = 0;
  int          exp_st[$];
  bit          exp_rdy[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    total++;
    assert (obs === ex) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
  endtask

  // Control table: state number, opcode, ready -> expected control vector
  function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] o, input bit rdy);
    logic pw, mw, iw, rw, asa, io, br, bn, ze, ret, tr;
    logic [1:0] m2r, rd, asb, ps, ao;
    {pw, mw, iw, rw, asa, io, br, bn, ze, ret, tr} = '0;
    {m2r, rd, asb, ps, ao} = '0;
    case (st)
      0:  begin asb = 2'b01; pw = rdy; iw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 2'b01; ret = 1; end
      5:  begin io = 1; mw = 1; ret = rdy; end
      6:  begin asa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; ret = 1; end
      8:  begin asa = 1; ao = 2'b01; ps = 2'b01; br = (o == BEQ); bn = (o == BNE); ret = 1; end
      9:  begin asa = 1; asb = 2'b10; if (o == ANDI || o == ORI) begin ao = 2'b11; ze = 1; end end
      10: begin rw = 1; ret = 1; end
      11: begin ps = 2'b10; pw = 1; ret = 1; end
      12: begin ps = 2'b10; pw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; ret = 1; end
      13: tr = 1;
      default: ;
    endcase
    return {pw, mw, iw, rw, asa, io, br, bn, ze, m2r, rd, asb, ps, ao, ret, tr};
  endfunction

  task automatic push(input int s, input bit r);
    exp_st.push_back(s);
    exp_rdy.push_back(r);
  endtask

  // Expected path of one instruction; releases reset on the first step.
  task automatic run_instr(input bit d2, input logic [5:0] o, input int unsigned wf, input int unsigned wm);
    logic [20:0] ev;
    bit ext;
    bool_legal: begin end
    ext = !d2;
    if (d2) begin wf = 0; wm = 0; end
    exp_st.delete(); exp_rdy.delete();
    repeat (wf) push(0, 0);
    push(0, 1);
    push(1, 1);
    case (o)
      LW:             begin push(2, 1); repeat (wm) push(3, 0); push(3, 1); push(4, 1); end
      SW:             begin push(2, 1); repeat (wm) push(5, 0); push(5, 1); end
      RT:             begin push(6, 1); push(7, 1); end
      BEQ:            push(8, 1);
      ADDI:           begin push(9, 1); push(10, 1); end
      J:              push(11, 1);
      BNE:            if (ext) push(8, 1); else push(13, 1);
      ANDI, ORI:      if (ext) begin push(9, 1); push(10, 1); end else push(13, 1);
      JAL:            if (ext) push(12, 1); else push(13, 1);
      default:        push(13, 1);
    endcase
    foreach (exp_st[i]) begin
      @(negedge clk);
      reset_n = 1'b1;
      if (d2) begin op2 = o; mr2 = 1'b0; mr1 = 1'b0; end
      else    begin op1 = o; mr1 = exp_rdy[i]; end
      #1;
      ev = exp_ctrl(exp_st[i], o, exp_rdy[i]);
      if (d2) begin
        chk("state2", {28'd0, st2}, exp_st[i]);
        chk("ctrl2", {11'd0, ctl2}, {11'd0, ev});
        chk("count2", {30'd0, cnt2}, m_cnt2);
        if (ev[1]) m_cnt2 = (m_cnt2 + 1) % 4;
      end else begin
        chk("state1", {28'd0, st1}, exp_st[i]);
        chk("ctrl1", {11'd0, ctl1}, {11'd0, ev});
        chk("count1", cnt1, m_cnt1);
        if (ev[1]) m_cnt1 = m_cnt1 + 1;
      end
    end
    if (exp_st[exp_st.size()-1] == 13) begin
      repeat (20) begin
        @(negedge clk); #1;
        chk("trap_state", d2 ? {28'd0, st2} : {28'd0, st1}, 13);
        chk("trap_flag", d2 ? {31'd0, trap2} : {31'd0, trap1}, 1);
      end
    end
  endtask

  // Leaves reset asserted; the next run_instr releases it on a negedge.
  task automatic do_reset();
    @(negedge clk);
    mr1 = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_state1", {28'd0, st1}, 0);
    chk("rst_trap1", {31'd0, trap1}, 0);
    chk("rst_count1", cnt1, 0);
    chk("rst_strobe1", {28'd0, pw1, iw1, rw1, ret1}, 0);
    chk("rst_state2", {28'd0, st2}, 0);
    chk("rst_count2", {30'd0, cnt2}, 0);
    m_cnt1 = 0;
    m_cnt2 = 0;
    @(negedge clk); #1;
    chk("rst_hold1", {30'd0, st1 == 4'd0, iw1}, 32'd2);
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, J, JAL};
    reset_n = 1'b0;
    op1 = RT; op2 = RT; mr1 = 1'b0; mr2 = 1'b0;

    do_reset();
    run_instr(0, LW, 0, 0);
    @(negedge clk); mr1 = 1'b0; #1;
    chk("lw_count", cnt1, 1);
    run_instr(0, SW, 0, 3);

    for (int n = 0; n < 40; n++)
      run_instr(0, ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3));

    do_reset();
    run_instr(0, ORI, 0, 0);
    run_instr(0, BNE, 0, 0);
    run_instr(0, JAL, 0, 0);
    @(negedge clk); mr1 = 1'b0; #1;
    chk("ext_count", cnt1, 3);

    run_instr(0, BAD, 0, 0);
    do_reset();

    // Reset asserted mid-RTYPEEX must abort without a register write
    @(negedge clk); reset_n = 1'b1; op1 = RT; mr1 = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("mid_rtypeex", {28'd0, st1}, 6);
    reset_n = 1'b0; #1;
    chk("mid_rst_state", {28'd0, st1}, 0);
    chk("mid_rst_strobes", {28'd0, pw1, iw1, rw1, ret1}, 0);
    @(negedge clk); #1;
    chk("mid_rst_hold", {27'd0, st1, rw1}, 0);
    m_cnt1 = 0;
    run_instr(0, ADDI, 1, 0);

    do_reset();
    mr1 = 1'b0;
    run_instr(1, JAL, 0, 0);
    do_reset();
    mr1 = 1'b0;
    run_instr(1, LW, 0, 0);
    run_instr(1, RT, 0, 0);
    run_instr(1, ADDI, 0, 0);
    run_instr(1, BEQ, 0, 0);
    run_instr(1, J, 0, 0);
    @(negedge clk); #1;
    chk("wrap_count2", {30'd0, cnt2}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
